// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT frame receiver and its helpers.
package fft_pkg;
  localparam int W_DEF = 8;
  localparam int NBINS = 8;
  localparam int BIN_W = 3;

  localparam logic [BIN_W-1:0] BIN_DC   = 3'd0;
  localparam logic [BIN_W-1:0] BIN_NYQ  = 3'd4;
  localparam logic [BIN_W-1:0] BIN_LAST = 3'd7;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    COMMIT    = 1'b1
  } rx_state_e;
endpackage

// File: rtl/fft_frame_rx_if.sv
// Bin stream in, committed frame out. Inputs are sampled on fastclk; frame_valid is a
// one-cycle pulse and the bin outputs hold their value until the next frame_valid.
interface fft_frame_rx_if #(parameter int W = fft_pkg::W_DEF) ();
  logic                  sample_clk;
  logic                  resync;
  logic [W-1:0]          in_re;
  logic [W-1:0]          in_im;
  logic [W-1:0]          y0, y4;
  logic [W-1:0]          yr1, yi1, yr2, yi2, yr3, yi3;
  logic [W-1:0]          yr5, yi5, yr6, yi6, yr7, yi7;
  logic                  frame_valid;
  logic [7:0]            frame_cnt;
  logic                  align_err;
  fft_pkg::rx_state_e    dbg_state;
  logic [fft_pkg::BIN_W-1:0] dbg_bin_idx;

  modport master (
    output sample_clk, resync, in_re, in_im,
    input  y0, y4, yr1, yi1, yr2, yi2, yr3, yi3, yr5, yi5, yr6, yi6, yr7, yi7,
    input  frame_valid, frame_cnt, align_err, dbg_state, dbg_bin_idx
  );

  modport slave (
    input  sample_clk, resync, in_re, in_im,
    output y0, y4, yr1, yi1, yr2, yi2, yr3, yi3, yr5, yi5, yr6, yi6, yr7, yi7,
    output frame_valid, frame_cnt, align_err, dbg_state, dbg_bin_idx
  );
endinterface

// File: rtl/fft_strobe_sync.sv
// Two-flop synchronizer for a slow asynchronous strobe plus a rising-edge detector.
module fft_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_in,
  output logic rise
);
  // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], strobe_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/fft_frame_rx.sv
// Reassembles 8 serialized FFT bins into parallel outputs, committed atomically per frame.
// Optional alignment checker enabled by defining FFT_RX_ALIGN_CHECK_EN.
module fft_frame_rx
  import fft_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           fastclk,
  input  logic           rst_n,
  fft_frame_rx_if.slave  rx
);
  logic strobe_rise;

  fft_strobe_sync u_sync (
    .clk       (fastclk),
    .rst_n     (rst_n),
    .strobe_in (rx.sample_clk),
    .rise      (strobe_rise)
  );

  rx_state_e        state_q, state_d;
  logic [BIN_W-1:0] bin_idx_q, bin_idx_d;
  logic [2*W-1:0]   shadow_q [NBINS];
  logic [2*W-1:0]   shadow_d [NBINS];
  logic [W-1:0]     out_re_q [NBINS];
  logic [W-1:0]     out_re_d [NBINS];
  logic [W-1:0]     out_im_q [NBINS];
  logic [W-1:0]     out_im_d [NBINS];
  logic             frame_valid_q, frame_valid_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d       = state_q;
    bin_idx_d     = bin_idx_q;
    shadow_d      = shadow_q;
    out_re_d      = out_re_q;
    out_im_d      = out_im_q;
    frame_valid_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    unique case (state_q)
      WAIT_EDGE: begin
        // resync beats a coincident strobe: the sample is dropped, not stored as bin 0
        if (rx.resync) begin
          bin_idx_d = '0;
        end else if (strobe_rise) begin
          shadow_d[bin_idx_q] = {rx.in_re, rx.in_im};
          if (bin_idx_q == BIN_LAST) state_d = COMMIT;
          else                       bin_idx_d = bin_idx_q + 3'd1;
        end
      end
      COMMIT: begin
        for (int k = 0; k < NBINS; k++) begin
          out_re_d[k] = shadow_q[k][2*W-1:W];
          out_im_d[k] = shadow_q[k][W-1:0];
        end
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 8'd1;
        bin_idx_d     = '0;
        state_d       = WAIT_EDGE;
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_EDGE;
      bin_idx_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      for (int k = 0; k < NBINS; k++) begin
        shadow_q[k] <= '0;
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      bin_idx_q     <= bin_idx_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      shadow_q      <= shadow_d;
      out_re_q      <= out_re_d;
      out_im_q      <= out_im_d;
    end
  end

`ifdef FFT_RX_ALIGN_CHECK_EN
  // A nonzero imaginary part on a real-only bin means the stream is off by some bins
  logic align_err_q, align_err_d;

  always_comb begin
    align_err_d = align_err_q;
    if (state_q == WAIT_EDGE && strobe_rise &&
        (bin_idx_q == BIN_DC || bin_idx_q == BIN_NYQ) && rx.in_im != '0)
      align_err_d = 1'b1;
    if (rx.resync) align_err_d = 1'b0;
  end

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) align_err_q <= 1'b0;
    else        align_err_q <= align_err_d;
  end

  assign rx.align_err = align_err_q;
`else
  assign rx.align_err = 1'b0;
`endif

  assign rx.y0  = out_re_q[0];
  assign rx.yr1 = out_re_q[1];
  assign rx.yi1 = out_im_q[1];
  assign rx.yr2 = out_re_q[2];
  assign rx.yi2 = out_im_q[2];
  assign rx.yr3 = out_re_q[3];
  assign rx.yi3 = out_im_q[3];
  assign rx.y4  = out_re_q[4];
  assign rx.yr5 = out_re_q[5];
  assign rx.yi5 = out_im_q[5];
  assign rx.yr6 = out_re_q[6];
  assign rx.yi6 = out_im_q[6];
  assign rx.yr7 = out_re_q[7];
  assign rx.yi7 = out_im_q[7];

  assign rx.frame_valid = frame_valid_q;
  assign rx.frame_cnt   = frame_cnt_q;
  assign rx.dbg_state   = state_q;
  assign rx.dbg_bin_idx = bin_idx_q;
endmodule

// File: tb/tb_fft_frame_rx.sv
// Bench for fft_frame_rx: drives strobed bin streams and scoreboards committed frames.
// Define FFT_RX_ALIGN_CHECK_EN for both bench and RTL to exercise the alignment checker.
module tb_fft_frame_rx;
  import fft_pkg::*;

  localparam int W    = 8;
  localparam int HALF = 6;

  logic fastclk;
  logic rst_n;

  fft_frame_rx_if #(.W(W)) rx_if ();

  fft_frame_rx #(.W(W)) dut (
    .fastclk (fastclk),
    .rst_n   (rst_n),
    .rx      (rx_if)
  );

  // clock / reset
  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  int checks;
  int errors;
  int cyc;
  int rise_cyc;
  int fv_cyc;
  int fv_count;
  int fv_base;
  int exp_cnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] fr_re [8];
  logic [W-1:0] fr_im [8];
  logic [W-1:0] a_re  [8];
  logic [W-1:0] a_im  [8];

  always @(posedge fastclk) cyc <= cyc + 1;

  // snapshot of the bin outputs whenever a frame is announced
  always @(negedge fastclk) begin
    if (rx_if.frame_valid === 1'b1) begin
      fv_count <= fv_count + 1;
      fv_cyc   <= cyc;
      got_q.push_back(rx_if.y0);
      got_q.push_back(rx_if.yr1); got_q.push_back(rx_if.yi1);
      got_q.push_back(rx_if.yr2); got_q.push_back(rx_if.yi2);
      got_q.push_back(rx_if.yr3); got_q.push_back(rx_if.yi3);
      got_q.push_back(rx_if.y4);
      got_q.push_back(rx_if.yr5); got_q.push_back(rx_if.yi5);
      got_q.push_back(rx_if.yr6); got_q.push_back(rx_if.yi6);
      got_q.push_back(rx_if.yr7); got_q.push_back(rx_if.yi7);
    end
  end

  function automatic logic [14*W-1:0] outputs_flat();
    return {rx_if.y0, rx_if.yr1, rx_if.yi1, rx_if.yr2, rx_if.yi2, rx_if.yr3, rx_if.yi3,
            rx_if.y4, rx_if.yr5, rx_if.yi5, rx_if.yr6, rx_if.yi6, rx_if.yr7, rx_if.yi7};
  endfunction

  function automatic logic [14*W-1:0] flat_of(input logic [W-1:0] re [8], input logic [W-1:0] im [8]);
    return {re[0], re[1], im[1], re[2], im[2], re[3], im[3],
            re[4], re[5], im[5], re[6], im[6], re[7], im[7]};
  endfunction

  // driver tasks
  task automatic send_bin(input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge fastclk);
    rx_if.in_re      = re;
    rx_if.in_im      = im;
    rx_if.sample_clk = 1'b1;
    rise_cyc         = cyc;
    repeat (HALF) @(negedge fastclk);
    rx_if.sample_clk = 1'b0;
    repeat (HALF - 1) @(negedge fastclk);
  endtask

  task automatic send_frame();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(fr_re[k]);
      if (k != 0 && k != 4) exp_q.push_back(fr_im[k]);
    end
    exp_cnt = (exp_cnt + 1) % 256;
    for (int k = 0; k < 8; k++) send_bin(fr_re[k], fr_im[k]);
  endtask

  task automatic pulse_resync();
    @(negedge fastclk);
    rx_if.resync = 1'b1;
    @(negedge fastclk);
    rx_if.resync = 1'b0;
  endtask

  task automatic random_frame();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = W'($urandom_range(1, 255));
      fr_im[k] = (k == 0 || k == 4) ? '0 : W'($urandom_range(0, 255));
    end
  endtask

  // scoreboard: drain expected bins against snapshots, plus frame count and latency
  task automatic check_frames(input int n, input string name);
    logic [W-1:0] e, g;
    repeat (4) @(negedge fastclk);
    checks++;
    if (fv_count - fv_base !== n) begin
      errors++;
      $display("FAIL %s frame_valid_pulses got %0d exp %0d", name, fv_count - fv_base, n);
    end
    fv_base = fv_count;
    if (n > 0) begin
      checks++;
      if (fv_cyc - rise_cyc < 3 || fv_cyc - rise_cyc > 5) begin
        errors++;
        $display("FAIL %s latency got %0d exp 3..5", name, fv_cyc - rise_cyc);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL %s missing_bin got none exp %0d", name, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL %s bin_value got %0d exp %0d", name, g, e);
        end
      end
    end
    if (got_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s extra_bins got %0d exp 0", name, got_q.size());
      got_q.delete();
    end
    checks++;
    if (rx_if.frame_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d exp %0d", name, rx_if.frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (outputs_flat() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", outputs_flat());
    end
    @(negedge fastclk);
    rst_n = 1'b1;
    repeat (3) @(negedge fastclk);
    checks++;
    if (outputs_flat() !== '0 || rx_if.frame_cnt !== 8'd0 || rx_if.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %h/%0d/%b exp 0/0/0", outputs_flat(), rx_if.frame_cnt, rx_if.frame_valid);
    end
    checks++;
    if (rx_if.align_err !== 1'b0 || rx_if.dbg_state !== WAIT_EDGE || rx_if.dbg_bin_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got %b/%0d/%0d exp 0/0/0", rx_if.align_err, rx_if.dbg_state, rx_if.dbg_bin_idx);
    end
  endtask

  task automatic test_single_frame();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = W'(10 + k);
      fr_im[k] = (k == 0 || k == 4) ? '0 : W'(20 + k);
    end
    send_frame();
    check_frames(1, "single_frame");
  endtask

  task automatic test_back_to_back();
    random_frame();
    a_re = fr_re;
    a_im = fr_im;
    send_frame();
    random_frame();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(fr_re[k]);
      if (k != 0 && k != 4) exp_q.push_back(fr_im[k]);
    end
    exp_cnt = (exp_cnt + 1) % 256;
    for (int k = 0; k < 8; k++) begin
      send_bin(fr_re[k], fr_im[k]);
      if (k == 3 || k == 6) begin
        checks++;
        if (outputs_flat() !== flat_of(a_re, a_im)) begin
          errors++;
          $display("FAIL back_to_back_hold got %h exp %h", outputs_flat(), flat_of(a_re, a_im));
        end
      end
    end
    check_frames(2, "back_to_back");
  endtask

  task automatic test_resync();
    for (int k = 0; k < 3; k++) send_bin(W'(90 + k), W'(60 + k));
    pulse_resync();
    random_frame();
    send_frame();
    check_frames(1, "resync_partial");
  endtask

  task automatic test_resync_edge();
    send_bin(8'h71, 8'h00);
    send_bin(8'h72, 8'h12);
    // raise the strobe, then hold resync across the cycle the detected edge is live
    @(negedge fastclk);
    rx_if.in_re      = 8'h77;
    rx_if.in_im      = 8'h00;
    rx_if.sample_clk = 1'b1;
    @(negedge fastclk);
    @(negedge fastclk);
    rx_if.resync = 1'b1;
    @(negedge fastclk);
    rx_if.resync = 1'b0;
    repeat (HALF - 3) @(negedge fastclk);
    rx_if.sample_clk = 1'b0;
    repeat (HALF - 1) @(negedge fastclk);
    checks++;
    if (rx_if.dbg_bin_idx !== 3'd0) begin
      errors++;
      $display("FAIL resync_edge_idx got %0d exp 0", rx_if.dbg_bin_idx);
    end
    random_frame();
    send_frame();
    check_frames(1, "resync_edge");
  endtask

  task automatic test_reset_mid_frame();
    random_frame();
    for (int k = 0; k < 5; k++) send_bin(fr_re[k], fr_im[k]);
    checks++;
    if (rx_if.dbg_bin_idx !== 3'd5) begin
      errors++;
      $display("FAIL mid_frame_idx got %0d exp 5", rx_if.dbg_bin_idx);
    end
    @(negedge fastclk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outputs_flat() !== '0 || rx_if.frame_cnt !== 8'd0 || rx_if.dbg_bin_idx !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got %h/%0d/%0d exp 0/0/0", outputs_flat(), rx_if.frame_cnt, rx_if.dbg_bin_idx);
    end
    @(negedge fastclk);
    rst_n = 1'b1;
    exp_cnt = 0;
    fv_base = fv_count;
    repeat (2) @(negedge fastclk);
    random_frame();
    send_frame();
    check_frames(1, "after_reset");
  endtask

  task automatic test_align();
    random_frame();
    fr_im[4] = 8'h05;
    send_frame();
    check_frames(1, "align_frame");
`ifdef FFT_RX_ALIGN_CHECK_EN
    checks++;
    if (rx_if.align_err !== 1'b1) begin
      errors++;
      $display("FAIL align_set got %b exp 1", rx_if.align_err);
    end
    random_frame();
    send_frame();
    check_frames(1, "align_sticky_frame");
    checks++;
    if (rx_if.align_err !== 1'b1) begin
      errors++;
      $display("FAIL align_sticky got %b exp 1", rx_if.align_err);
    end
    pulse_resync();
    @(negedge fastclk);
    checks++;
    if (rx_if.align_err !== 1'b0) begin
      errors++;
      $display("FAIL align_clear got %b exp 0", rx_if.align_err);
    end
`else
    checks++;
    if (rx_if.align_err !== 1'b0) begin
      errors++;
      $display("FAIL align_disabled got %b exp 0", rx_if.align_err);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rise_cyc = 0;
    fv_cyc   = 0;
    fv_count = 0;
    fv_base  = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    rx_if.sample_clk = 1'b0;
    rx_if.resync     = 1'b0;
    rx_if.in_re      = '0;
    rx_if.in_im      = '0;
    repeat (3) @(negedge fastclk);

    test_reset();
    test_single_frame();
    test_back_to_back();
    test_resync();
    test_resync_edge();
    test_reset_mid_frame();
    test_align();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_rx.md
Name: fft_frame_rx

Overview:
- Receive-side counterpart of the FFT result serializer.
- Samples the complex stream in_re/in_im, one FFT bin per rising edge of the slow strobe clock sample_clk, inside the fastclk domain.
- Reassembles the 8 bins into parallel registers that match the serializer's bus ordering (y0, yr1/yi1 … yr7/yi7, y4).
- Presents each complete frame atomically with a one-cycle frame_valid pulse; feeds downstream magnitude/display logic or loop-back verification.

Parameters:
- W, 8, data width of in_re/in_im and of every bin output (16 in the integrated design).
- NBINS, 8, bins per frame; fixed at 8 in this revision; bin_idx is 3 bits.

Ports:
- fastclk  in  1  system clock; all logic is clocked on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_clk  in  1  slow strobe from the transmitter; treated as asynchronous data.
- resync  in  1  single-cycle pulse: realign so the next strobe edge is bin 0.
- in_re  in  W  real part of the current bin.
- in_im  in  W  imaginary part of the current bin.
- y0, y4  out  W  real-only bins 0 and 4.
- yr1,yi1,yr2,yi2,yr3,yi3,yr5,yi5,yr6,yi6,yr7,yi7  out  W each  complex bins.
- frame_valid  out  1  one-cycle pulse when the bin outputs have just updated.
- frame_cnt  out  8  count of completed frames; wraps 255->0.
- align_err  out  1  sticky flag for an alignment violation (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): all bin outputs, frame_cnt, align_err, frame_valid, bin_idx, shadow registers and sync flops go to 0; state = WAIT_EDGE.
- Strobe sync and edge detect:
  - sample_clk passes through 2 flops (s1, s2), then s3 for edge detect.
  - edge = s2 & ~s3.
  - Capture latency is 3 fastclk cycles after the sample_clk rising edge.
  - Minimum sample_clk high and low time is 4 fastclk cycles. in_re/in_im must be stable from 1 cycle after the strobe edge until the next edge. Nominal strobe is 26 fastclk cycles per half period.
- FSM:
  - WAIT_EDGE: idle until edge. On edge, write {in_re, in_im} into shadow[bin_idx]. If bin_idx==7, go to COMMIT; else bin_idx+1.
  - COMMIT (1 cycle):
    - Copy shadow to outputs: shadow[0].re->y0, shadow[4].re->y4, shadow[k]->yrk/yik.
    - Assert frame_valid; frame_cnt+1; bin_idx=0; return to WAIT_EDGE.
    - Outputs update only here, so downstream never sees a mixed frame.
- Imaginary parts of bins 0 and 4 are captured into shadow but not output.
- An edge arriving during COMMIT cannot occur given the 4-cycle minimum; no buffering is provided for it.
- resync=1:
  - bin_idx=0 and the partial frame is discarded; outputs keep the last committed frame.
  - resync wins over a coincident edge, and that sample is dropped.
  - resync during COMMIT: the commit completes, then bin_idx=0.
- Reset mid-frame: everything clears; the first edge after release is bin 0.
- No arithmetic on the data path; values are passed bit-exact.

Optional Feature:
- FFT_RX_ALIGN_CHECK_EN defined:
  - On capture of bin 0 or bin 4, in_im!=0 sets align_err (sticky).
  - align_err is cleared only by rst_n or resync.
  - This detects a stream that is not aligned to bin 0.
- Not defined: align_err is tied to 0 and no comparators are synthesized.

Decomposition:
- Shared package fft_pkg: W default, NBINS, bin index constants (BIN_DC=0, BIN_NYQ=4), FSM state encoding (WAIT_EDGE, COMMIT).
- One natural sub-module, fft_strobe_sync: the 2-flop synchronizer plus rising-edge detector, reusable by other slow-clock consumers.

Test Plan:
- Reset release, then 8 strobes with re=10,11..17 and im=0,21..23,0,25..27:
  - 3 cycles after the 8th edge, frame_valid pulses once.
  - y0=10, yr1=11/yi1=21, y4=14, yr7=17/yi7=27; frame_cnt=1.
- Two back-to-back frames with distinct values:
  - Outputs hold frame 1 values, unchanged during frame 2 capture, until frame 2's COMMIT.
  - frame_cnt=2.
- resync after 3 edges, then 8 edges of a new frame:
  - The first post-resync sample lands in y0.
  - Only one frame_valid is seen; the partial frame is discarded.
- resync asserted on the same cycle as an edge: that sample is dropped, and the next edge is bin 0.
- rst_n pulsed low asynchronously mid-frame (bin_idx=5):
  - All outputs read 0 immediately.
  - The next full frame is captured correctly.
- With FFT_RX_ALIGN_CHECK_EN, bin 4 sent with im=8'h05:
  - align_err=1 and stays set across later frames.
  - resync clears it.
  - Without the macro, align_err stays 0.
